// File: rtl/rcpu_io_pkg.sv
// rcpu_io_pkg: register offsets and STATUS bit layout
// shared by RCPU I/O bus peripherals.
package rcpu_io_pkg;

  typedef logic [1:0] reg_off_t;

  localparam reg_off_t REG_DATA   = 2'd0;
  localparam reg_off_t REG_STATUS = 2'd1;
  localparam reg_off_t REG_DIV    = 2'd2;
  localparam reg_off_t REG_RSVD   = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_TX_BUSY    = 4;

endpackage

// File: rtl/rcpu_io_uart_if.sv
// rcpu_io_uart_if: RCPU I/O bus (strobes, address,
// write data, registered read data); master=CPU, slave=peripheral.
interface rcpu_io_uart_if;
  logic        io_read_enable;
  logic        io_write_enable;
  logic [15:0] io_address;
  logic [15:0] io_write_data;
  logic [15:0] io_read_data;

  modport master (
    output io_read_enable,
    output io_write_enable,
    output io_address,
    output io_write_data,
    input  io_read_data
  );

  modport slave (
    input  io_read_enable,
    input  io_write_enable,
    input  io_address,
    input  io_write_data,
    output io_read_data
  );
endinterface

// File: rtl/rcpu_fifo.sv
// rcpu_fifo: synchronous FIFO, head visible on dout.
// Ports: push/din, pop/dout, full, empty; clk, resetq.
module rcpu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // a push into a full FIFO is fine when a pop frees a slot
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rcpu_io_uart.sv
// rcpu_io_uart: 4-register I/O-bus UART (DATA, STATUS, DIV, rsvd)
// Ports: clk, resetq, io (bus slave), uart_tx, uart_rx (8N1).
module rcpu_io_uart #(
  parameter logic [15:0] BASE_ADDR  = 16'h0010,
  parameter logic [15:0] DIV_RESET  = 16'd104,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            resetq,
  rcpu_io_uart_if.slave   io,
  output logic            uart_tx,
  input  logic            uart_rx
);

  import rcpu_io_pkg::*;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [15:0] off;
  logic        win;
  reg_off_t    sel;
  logic        rd;
  logic        wr;
  logic [15:0] div_q;
  logic [15:0] rd_q;
  logic        rx_ovr;
  logic [15:0] status_w;

  logic       tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0] tx_dout;
  logic       rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0] rx_dout;

  // unsigned wrap makes below-base addresses land far out of window
  assign off = io.io_address - BASE_ADDR;
  assign win = (off < 16'd4);
  assign sel = off[1:0];
  assign rd  = io.io_read_enable && win;
  assign wr  = io.io_write_enable && win;

  assign tx_push = wr && (sel == REG_DATA);
  assign rx_pop  = rd && (sel == REG_DATA);
  assign io.io_read_data = rd_q;

  rcpu_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .resetq(resetq),
    .push(tx_push), .din(io.io_write_data[7:0]),
    .pop(tx_pop), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty)
  );

  // ---------------- TX engine ----------------
  logic [1:0]  tx_st;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_tick;

  assign tx_tick = (tx_cnt == 16'd0);
  // STOP chains straight into the next START
  assign tx_pop  = !tx_empty &&
                   ((tx_st == S_IDLE) ||
                    ((tx_st == S_STOP) && tx_tick));

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else if (tx_pop) begin
      tx_st  <= S_START;
      tx_sh  <= tx_dout;
      tx_cnt <= div_q;
    end else if (tx_st != S_IDLE) begin
      if (!tx_tick) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else begin
        tx_cnt <= div_q;
        unique case (tx_st)
          S_START: begin
            tx_st  <= S_DATA;
            tx_bit <= '0;
          end
          S_DATA: begin
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_st <= S_STOP;
          end
          default: tx_st <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    unique case (tx_st)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = tx_sh[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // ---------------- RX engine ----------------
  logic        rx_m, rx_s, rx_prev;
  logic [1:0]  rx_st;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_tick;
  logic [15:0] half;

  // (DIV+1)/2 without a 17-bit intermediate
  assign half    = {1'b0, div_q[15:1]} + {15'd0, div_q[0]};
  assign rx_tick = (rx_cnt == 16'd0);
  assign rx_push = (rx_st == S_STOP) && rx_tick && rx_s;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= uart_rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_st  <= S_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else if (rx_st == S_IDLE) begin
      if (rx_prev && !rx_s) begin
        rx_st  <= S_START;
        rx_cnt <= (half == 16'd0) ? 16'd0 : half - 16'd1;
      end
    end else if (!rx_tick) begin
      rx_cnt <= rx_cnt - 16'd1;
    end else begin
      rx_cnt <= div_q;
      unique case (rx_st)
        S_START: begin
          rx_bit <= '0;
          rx_st  <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          rx_sh  <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= S_STOP;
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  rcpu_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .resetq(resetq),
    .push(rx_push), .din(rx_sh),
    .pop(rx_pop), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty)
  );

  // ---------------- registers ----------------
  always_comb begin
    status_w = '0;
    status_w[ST_TX_FULL]    = tx_full;
    status_w[ST_TX_EMPTY]   = tx_empty;
    status_w[ST_RX_EMPTY]   = rx_empty;
    status_w[ST_RX_OVERRUN] = rx_ovr;
    status_w[ST_TX_BUSY]    = (tx_st != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      div_q <= DIV_RESET;
    end else if (wr && (sel == REG_DIV)) begin
      div_q <= io.io_write_data;
    end
  end

  // a pop in the same cycle still makes room, so no overrun then
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_ovr <= 1'b0;
    end else if (rx_push && rx_full && !rx_pop) begin
      rx_ovr <= 1'b1;
    end else if (rd && (sel == REG_STATUS)) begin
      rx_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd_q <= '0;
    end else if (rd) begin
      unique case (1'b1)
        (sel == REG_DATA):
          rd_q <= rx_empty ? 16'h0000 : {8'h00, rx_dout};
        (sel == REG_STATUS):
          rd_q <= status_w;
        (sel == REG_DIV):
          rd_q <= div_q;
        default:
          rd_q <= 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_rcpu_io_uart.sv
// tb_rcpu_io_uart: randomized self-checking bench for rcpu_io_uart
// with a serial frame decoder and queue-based FIFO models.
module tb_rcpu_io_uart;

  localparam logic [15:0] BASE = 16'h0010;
  localparam logic [15:0] A_DATA = BASE;
  localparam logic [15:0] A_STAT = BASE + 16'd1;
  localparam logic [15:0] A_DIV  = BASE + 16'd2;
  localparam logic [15:0] A_RSVD = BASE + 16'd3;

  logic clk = 1'b0;
  logic resetq;
  logic rx_drv;
  logic loop;
  logic uart_tx;
  logic uart_rx;

  int n_chk = 0;
  int n_pass = 0;
  int mon_p = 105;
  logic [7:0] txq[$];

  rcpu_io_uart_if io ();

  assign uart_rx = loop ? uart_tx : rx_drv;

  rcpu_io_uart #(
    .BASE_ADDR(16'h0010),
    .DIV_RESET(16'd104),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .resetq(resetq),
    .io(io),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // decodes every frame seen on uart_tx, bit period mon_p clocks
  task automatic mstep(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin : mon
    int p;
    logic [7:0] b;
    forever begin
      mstep(1);
      if (resetq === 1'b1 && uart_tx === 1'b0) begin
        p = mon_p;
        b = '0;
        mstep(p / 2);
        for (int i = 0; i < 8; i++) begin
          mstep(p);
          b[i] = uart_tx;
        end
        mstep(p);
        txq.push_back(b);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] d);
    io.io_read_enable  = r;
    io.io_write_enable = w;
    io.io_address      = a;
    io.io_write_data   = d;
    @(posedge clk); #1;
    io.io_read_enable  = 1'b0;
    io.io_write_enable = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    bus(1'b1, 1'b0, a, 16'h0);
    v = io.io_read_data;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus(1'b0, 1'b1, a, d);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop,
                         input int p);
    rx_drv = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(p);
    end
    rx_drv = stop;
    tick(p);
    rx_drv = 1'b1;
    tick(p);
  endtask

  function automatic logic [15:0] stat(input logic busy,
      input logic ovr, input int rxn, input int txn);
    return {11'd0, busy, ovr, (rxn == 0), (txn == 0), (txn >= 4)};
  endfunction

  task automatic test_reset();
    logic [15:0] v;
    resetq = 1'b0;
    tick(3);
    n_chk++;
    if (io.io_read_data !== 16'h0) $display("FAIL reset_rdata got=%h exp=0000", io.io_read_data);
    else n_pass++;
    n_chk++;
    if (uart_tx !== 1'b1) $display("FAIL reset_tx got=%b exp=1", uart_tx);
    else n_pass++;
    resetq = 1'b1;
    tick(2);
    rd(A_STAT, v);
    n_chk++;
    if (v !== stat(0, 0, 0, 0)) $display("FAIL reset_status got=%h exp=%h", v, stat(0, 0, 0, 0));
    else n_pass++;
    rd(A_DIV, v);
    n_chk++;
    if (v !== 16'd104) $display("FAIL reset_div got=%h exp=%h", v, 16'd104);
    else n_pass++;
  endtask

  task automatic test_regs();
    logic [15:0] v, d, e;
    d = 16'($urandom);
    e = 16'($urandom);
    wr(A_DIV, d);
    rd(A_DIV, v);
    n_chk++;
    if (v !== d) $display("FAIL div_rw got=%h exp=%h", v, d);
    else n_pass++;
    bus(1'b1, 1'b1, A_DIV, e);
    v = io.io_read_data;
    n_chk++;
    if (v !== d) $display("FAIL div_rmw_old got=%h exp=%h", v, d);
    else n_pass++;
    wr(A_RSVD, 16'($urandom));
    rd(A_RSVD, v);
    n_chk++;
    if (v !== 16'h0) $display("FAIL rsvd_read got=%h exp=0000", v);
    else n_pass++;
    wr(BASE + 16'd4, 16'($urandom));
    wr(BASE - 16'd2, 16'($urandom));
    rd(A_DIV, v);
    n_chk++;
    if (v !== e) $display("FAIL div_after_ignored got=%h exp=%h", v, e);
    else n_pass++;
    rd(BASE + 16'd4, v);
    rd(BASE - 16'd1, v);
    n_chk++;
    if (v !== e) $display("FAIL oow_read_hold got=%h exp=%h", v, e);
    else n_pass++;
    wr(A_DIV, 16'd3);
    mon_p = 4;
  endtask

  task automatic test_tx_frame();
    logic [9:0] frame;
    logic [7:0] b;
    int errs;
    b = 8'hA5;
    frame = {1'b1, b, 1'b0};
    wr(A_DATA, {8'h00, b});
    n_chk++;
    if (uart_tx !== 1'b1) $display("FAIL tx_pre_start got=%b exp=1", uart_tx);
    else n_pass++;
    for (int j = 0; j < 10; j++) begin
      errs = 0;
      for (int k = 0; k < 4; k++) begin
        tick(1);
        if (uart_tx !== frame[j]) errs++;
      end
      n_chk++;
      if (errs != 0) $display("FAIL tx_bit%0d got_bad_clocks=%0d exp_level=%b", j, errs, frame[j]);
      else n_pass++;
    end
    tick(4);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [15:0] v;
    txq.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(A_DATA, {8'($urandom), b});
    end
    rd(A_STAT, v);
    n_chk++;
    if (v !== stat(1, 0, 0, 4)) $display("FAIL b2b_status got=%h exp=%h", v, stat(1, 0, 0, 4));
    else n_pass++;
    wr(A_DATA, 16'($urandom));
    for (int i = 0; i < 800 && txq.size() < 5; i++) tick(1);
    n_chk++;
    if (txq.size() != 5) $display("FAIL b2b_count got=%0d exp=5", txq.size());
    else n_pass++;
    for (int i = 0; i < 5 && txq.size() > 0; i++) begin
      b = txq.pop_front();
      n_chk++;
      if (b !== exp_q[i]) $display("FAIL b2b_byte%0d got=%h exp=%h", i, b, exp_q[i]);
      else n_pass++;
    end
    tick(80);
    n_chk++;
    if (txq.size() != 0) $display("FAIL b2b_dropped got_extra=%0d exp=0", txq.size());
    else n_pass++;
    rd(A_STAT, v);
    n_chk++;
    if (v !== stat(0, 0, 0, 0)) $display("FAIL b2b_idle got=%h exp=%h", v, stat(0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    logic [15:0] v;
    loop = 1'b1;
    tick(2);
    for (int n = 0; n < 3; n++) begin
      b = (n == 0) ? 8'h3C : 8'($urandom);
      wr(A_DATA, {8'h00, b});
      v = 16'hFFFF;
      for (int i = 0; i < 200; i++) begin
        rd(A_STAT, v);
        if (v[2] == 1'b0) break;
      end
      n_chk++;
      if (v[2] !== 1'b0) $display("FAIL loop_rx_empty%0d got=%b exp=0", n, v[2]);
      else n_pass++;
      rd(A_DATA, v);
      n_chk++;
      if (v !== {8'h00, b}) $display("FAIL loop_data%0d got=%h exp=%h", n, v, {8'h00, b});
      else n_pass++;
      tick(12);
    end
    rd(A_DATA, v);
    n_chk++;
    if (v !== 16'h0) $display("FAIL loop_empty_read got=%h exp=0000", v);
    else n_pass++;
    loop = 1'b0;
    tick(4);
  endtask

  task automatic test_rx_overrun();
    logic [7:0] rxm[$];
    logic [7:0] b;
    logic ovr;
    logic [15:0] v, x;
    ovr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1, 4);
      if (rxm.size() < 4) rxm.push_back(b);
      else ovr = 1'b1;
    end
    rd(A_STAT, v);
    x = stat(0, ovr, rxm.size(), 0);
    n_chk++;
    if (v !== x) $display("FAIL ovr_status got=%h exp=%h", v, x);
    else n_pass++;
    rd(A_STAT, v);
    x = stat(0, 0, rxm.size(), 0);
    n_chk++;
    if (v !== x) $display("FAIL ovr_cleared got=%h exp=%h", v, x);
    else n_pass++;
    while (rxm.size() > 0) begin
      b = rxm.pop_front();
      rd(A_DATA, v);
      n_chk++;
      if (v !== {8'h00, b}) $display("FAIL ovr_data got=%h exp=%h", v, {8'h00, b});
      else n_pass++;
    end
    send_rx(8'($urandom), 1'b0, 4);
    rx_drv = 1'b0;
    tick(1);
    rx_drv = 1'b1;
    tick(12);
    rd(A_STAT, v);
    n_chk++;
    if (v !== stat(0, 0, 0, 0)) $display("FAIL rx_reject got=%h exp=%h", v, stat(0, 0, 0, 0));
    else n_pass++;
    b = 8'($urandom);
    send_rx(b, 1'b1, 4);
    rd(A_DATA, v);
    n_chk++;
    if (v !== {8'h00, b}) $display("FAIL rx_after_reject got=%h exp=%h", v, {8'h00, b});
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] v;
    int lows;
    wr(A_DATA, 16'h0000);
    wr(A_DATA, 16'($urandom));
    tick(10);
    resetq = 1'b0;
    #1;
    n_chk++;
    if (uart_tx !== 1'b1) $display("FAIL rst_tx_immediate got=%b exp=1", uart_tx);
    else n_pass++;
    @(posedge clk); #1;
    resetq = 1'b1;
    tick(2);
    rd(A_STAT, v);
    n_chk++;
    if (v !== stat(0, 0, 0, 0)) $display("FAIL rst_status got=%h exp=%h", v, stat(0, 0, 0, 0));
    else n_pass++;
    rd(BASE + 16'd7, v);
    n_chk++;
    if (v !== stat(0, 0, 0, 0)) $display("FAIL rst_oow_hold got=%h exp=%h", v, stat(0, 0, 0, 0));
    else n_pass++;
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      tick(1);
      if (uart_tx !== 1'b1) lows++;
    end
    n_chk++;
    if (lows != 0) $display("FAIL rst_no_resume got_low_clocks=%0d exp=0", lows);
    else n_pass++;
    rd(A_DIV, v);
    n_chk++;
    if (v !== 16'd104) $display("FAIL rst_div got=%h exp=%h", v, 16'd104);
    else n_pass++;
  endtask

  initial begin
    resetq = 1'b0;
    rx_drv = 1'b1;
    loop = 1'b0;
    io.io_read_enable  = 1'b0;
    io.io_write_enable = 1'b0;
    io.io_address      = 16'h0;
    io.io_write_data   = 16'h0;
    test_reset();
    test_regs();
    test_tx_frame();
    test_back_to_back();
    test_loopback();
    test_rx_overrun();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
